// File: rtl/fp2_pkg.sv
// Shared Fp2 arithmetic definitions over p = 2^255 - 19 with i^2 = -1.
// Holds the field constants, the multiplier latency and the modular helpers.
package fp2_pkg;
  localparam int FP_W        = 255;
  localparam int LAT_FP2_MUL = 29;

  typedef logic [FP_W-1:0] fp_t;
  typedef struct packed {
    fp_t re;
    fp_t im;
  } fp2_t;

  localparam logic [FP_W:0] P_EXT = (256'd1 << 255) - 256'd19;
  localparam fp_t           P     = P_EXT[FP_W-1:0];

  // Fold using 2^255 == 19 (mod p): two folds, then one conditional subtract.
  function automatic fp_t fp_red(input logic [2*FP_W+1:0] t);
    logic [FP_W+6:0] s;
    logic [FP_W:0]   r;
    s = (FP_W+7)'(t[FP_W-1:0]) + (FP_W+7)'(t[2*FP_W+1:FP_W]) * (FP_W+7)'(19);
    r = (FP_W+1)'(s[FP_W-1:0]) + (FP_W+1)'(s[FP_W+6:FP_W]) * (FP_W+1)'(19);
    if (r >= P_EXT) r = r - P_EXT;
    return r[FP_W-1:0];
  endfunction

  function automatic fp_t fp_sub(input fp_t a, input fp_t b);
    logic [FP_W:0] d;
    d = {1'b0, a} + {1'b0, P} - {1'b0, b};
    if (d >= P_EXT) d = d - P_EXT;
    return d[FP_W-1:0];
  endfunction
endpackage

// File: rtl/fp2_mul.sv
// Fixed-latency Fp2 multiplier: x = y*z, LAT_FP2_MUL cycles, never stalls.
// Stage 1 forms the four partial products, stage 2 reduces, the rest is delay.
module fp2_mul
  import fp2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  fp2_t y,
  input  fp2_t z,
  output fp2_t x
);
  localparam int PW = 2*FP_W + 2;

  logic [PW-1:0] ac, bd, ad, bc;
  fp2_t          dly [LAT_FP2_MUL-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac <= '0;
      bd <= '0;
      ad <= '0;
      bc <= '0;
    end else begin
      ac <= PW'(y.re) * PW'(z.re);
      bd <= PW'(y.im) * PW'(z.im);
      ad <= PW'(y.re) * PW'(z.im);
      bc <= PW'(y.im) * PW'(z.re);
    end
  end

  always_ff @(posedge clk) begin
    dly[0].re <= fp_sub(fp_red(ac), fp_red(bd));
    dly[0].im <= fp_red(ad + bc);
    for (int i = 1; i < LAT_FP2_MUL-1; i++) dly[i] <= dly[i-1];
  end

  assign x = dly[LAT_FP2_MUL-2];
endmodule

// File: rtl/fp2_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may share an edge.
// Pointers wrap naturally because DEPTH is a power of two.
module fp2_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fp2_mul_issue.sv
// Issue wrapper around fp2_mul: registered accept, valid/tag delay line matched
// to the multiplier, and a credit-guarded FWFT response FIFO.
module fp2_mul_issue
  import fp2_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FP_W-1:0]               in_y_re,
  input  logic [FP_W-1:0]               in_y_im,
  input  logic [FP_W-1:0]               in_z_re,
  input  logic [FP_W-1:0]               in_z_im,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [FP_W-1:0]               out_re,
  output logic [FP_W-1:0]               out_im,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   inflight,
  output logic                          idle
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT = LAT_FP2_MUL;
  localparam int RW  = 2*FP_W + TAG_W;

  logic                  acc, pop, rdy_en, empty, mul_rst;
  fp2_t                  op_y, op_z, x;
  logic [LAT:0]          vld_pipe;
  logic [LAT:0][TAG_W-1:0] tag_pipe;
  logic [RW-1:0]         rsp;

  // Credits cover every slot, so a result leaving the multiplier always fits.
  assign in_ready  = rdy_en && (inflight < CW'(FIFO_DEPTH));
  assign acc       = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign idle      = (inflight == '0);
  assign mul_rst   = ~rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      vld_pipe <= '0;
      inflight <= '0;
    end else begin
      rdy_en   <= 1'b1;
      vld_pipe <= {vld_pipe[LAT-1:0], acc};
      case ({acc, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    op_y     <= acc ? {in_y_re, in_y_im} : '0;
    op_z     <= acc ? {in_z_re, in_z_im} : '0;
    tag_pipe <= {tag_pipe[LAT-1:0], in_tag};
  end

  fp2_mul u_mul (
    .clk (clk),
    .rst (mul_rst),
    .y   (op_y),
    .z   (op_z),
    .x   (x)
  );

  fp2_rsp_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_pipe[LAT]),
    .din   ({x.re, x.im, tag_pipe[LAT]}),
    .pop   (pop),
    .dout  (rsp),
    .empty (empty)
  );

  // Storage is never reset, so the head is masked while nothing is valid.
  assign out_re  = out_valid ? rsp[RW-1 -: FP_W]   : '0;
  assign out_im  = out_valid ? rsp[TAG_W +: FP_W]  : '0;
  assign out_tag = out_valid ? rsp[TAG_W-1:0]      : '0;
endmodule

// File: tb/tb_fp2_mul_issue.sv
// Scoreboard bench for fp2_mul_issue: driver pushes model results on accept,
// a separate monitor pops and compares whenever a response is taken.
module tb_fp2_mul_issue;
  localparam int TAG_W = 4;
  localparam int DEPTH = 32;
  localparam logic [255:0] P256 = (256'd1 << 255) - 256'd19;
  localparam logic [511:0] P512 = {256'b0, P256};

  typedef struct packed {
    logic [254:0]     re;
    logic [254:0]     im;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [254:0]       in_y_re, in_y_im, in_z_re, in_z_im;
  logic [TAG_W-1:0]   in_tag;
  logic               in_valid, in_ready;
  logic [254:0]       out_re, out_im;
  logic [TAG_W-1:0]   out_tag;
  logic               out_valid, out_ready;
  logic [5:0]         inflight;
  logic               idle;

  always #5 clk = ~clk;

  fp2_mul_issue #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_y_re(in_y_re), .in_y_im(in_y_im), .in_z_re(in_z_re), .in_z_im(in_z_im),
    .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
    .out_re(out_re), .out_im(out_im), .out_tag(out_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .inflight(inflight), .idle(idle)
  );

  rsp_t q[$];
  int   total = 0, bad = 0;
  int   acc_cnt = 0, pop_cnt = 0;

  task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [254:0] mmul(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = ({257'b0, a} * {257'b0, b}) % P512;
    return t[254:0];
  endfunction

  // (a+bi)(c+di) = (ac - bd) + (ad + bc)i, straight from field arithmetic.
  function automatic rsp_t model(input logic [254:0] a, input logic [254:0] b,
                                 input logic [254:0] c, input logic [254:0] d,
                                 input logic [TAG_W-1:0] tg);
    rsp_t r;
    logic [255:0] re, im;
    re = ({1'b0, mmul(a, c)} + P256 - {1'b0, mmul(b, d)}) % P256;
    im = ({1'b0, mmul(a, d)} + {1'b0, mmul(b, c)}) % P256;
    r.re = re[254:0];
    r.im = im[254:0];
    r.tag = tg;
    return r;
  endfunction

  function automatic logic [254:0] rnd_fp();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    r[255] = 1'b0;
    r = r % P256;
    return r[254:0];
  endfunction

  task automatic rnd_inputs();
    in_y_re = rnd_fp();
    in_y_im = rnd_fp();
    in_z_re = rnd_fp();
    in_z_im = rnd_fp();
    in_tag  = TAG_W'($urandom);
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic cyc();
    #1;
    if (rst_n) begin
      chk("inflight", inflight, q.size());
      chk("idle", idle, q.size() == 0);
      if (in_valid && in_ready) begin
        q.push_back(model(in_y_re, in_y_im, in_z_re, in_z_im, in_tag));
        acc_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 300) begin cyc(); n++; end
    chk("drain_empty", q.size(), 0);
    cyc();
    chk("drain_idle", idle, 1);
  endtask

  // Monitor: compare every taken response; check hold-stability under backpressure.
  rsp_t         e;
  logic         hold = 1'b0;
  logic [513:0] prev;
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_re, out_im, out_tag}, prev);
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got tag %0h with no pending request", out_tag);
        end else begin
          e = q.pop_front();
          chk("rsp_re", out_re, e.re);
          chk("rsp_im", out_im, e.im);
          chk("rsp_tag", out_tag, e.tag);
        end
      end
    end
    hold = rst_n && out_valid && !out_ready;
    prev = {out_re, out_im, out_tag};
  end

  initial begin
    int n, a0, p0, seen;
    in_y_re = '0; in_y_im = '0; in_z_re = '0; in_z_im = '0; in_tag = '0;
    in_valid = 1'b1;
    out_ready = 1'b0;

    // Reset state, with in_valid high to show nothing is taken.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_out_data", {out_re, out_im, out_tag}, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", in_ready, 0);
    @(posedge clk);
    #1 chk("rdy_after_edge", in_ready, 1);
    @(negedge clk);

    // Single op with latency measurement.
    out_ready = 1'b1;
    in_y_re = 255'd3; in_y_im = 255'd5; in_z_re = 255'd7; in_z_im = 255'd11; in_tag = 4'hA;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin cyc(); n++; end
    chk("single_latency", n, 30);
    chk("single_re", out_re, P256[254:0] - 255'd34);
    chk("single_im", out_im, 68);
    chk("single_tag", out_tag, 4'hA);
    drain();

    // Edge operands: (-1 - i)(-1) = 1 + i.
    in_y_re = P256[254:0] - 255'd1; in_y_im = P256[254:0] - 255'd1;
    in_z_re = P256[254:0] - 255'd1; in_z_im = '0; in_tag = 4'h5;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin cyc(); n++; end
    chk("edge_latency", n, 30);
    chk("edge_re", out_re, 1);
    chk("edge_im", out_im, 1);
    drain();

    // Back-to-back stream at full rate.
    for (int i = 0; i < 64; i++) begin
      rnd_inputs();
      in_valid = 1'b1;
      #0 chk("stream_ready", in_ready, 1);
      cyc();
    end
    drain();

    // Backpressure until full, then one pop buys exactly one accept.
    out_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 80; i++) begin rnd_inputs(); in_valid = 1'b1; cyc(); end
    chk("bp_accepts", acc_cnt - a0, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_inflight", inflight, DEPTH);
    chk("bp_out_valid", out_valid, 1);
    a0 = acc_cnt;
    p0 = pop_cnt;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin rnd_inputs(); cyc(); end
    chk("bp_pulse_pops", pop_cnt - p0, 1);
    chk("bp_pulse_accepts", acc_cnt - a0, 1);
    chk("bp_refull", inflight, DEPTH);

    // From full: simultaneous push and pop for 100 cycles.
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin rnd_inputs(); in_valid = 1'b1; cyc(); end
    drain();

    // Mid-flight reset discards everything.
    for (int i = 0; i < 10; i++) begin rnd_inputs(); in_valid = 1'b1; cyc(); end
    in_valid = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      cyc();
    end
    chk("mid_rst_no_stale", seen, 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rnd_inputs();
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      cyc();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
